im_program_loader: RTL and testbench

//   Writer side of the byte-addressed instruction memory. Receives framed program bytes
//   on a valid/ready byte stream and writes them into the IM byte array, one byte per

---
 rtl/im_loader_pkg.sv | 8 +
 rtl/im_program_loader.sv | 97 +++++++++
 tb/tb_im_program_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared FSM state encoding, status codes and default frame marker for the IM program loader
package im_loader_pkg;
    typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, RESP} state_t;
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_CSUM  = 2'b01;
    localparam logic [1:0] ST_RANGE = 2'b10;
    localparam logic [7:0] SYNC_DEF = 8'hA5;
endpackage

// File: rtl/im_program_loader.sv
// im_program_loader: writes framed program bytes from a valid/ready stream into the IM byte array
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_data      incoming byte stream, s_ready accepts it
//   wr_en/wr_addr/wr_data  registered IM byte write port
//   cpu_hold            stalls the core while a frame is in flight
//   done/status         end-of-frame pulse and sticky result (ok / checksum / range)
module im_program_loader
    import im_loader_pkg::*;
#(
    parameter int         MEM_BYTES = 512,
    parameter int         ADDR_W    = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        status
);
    state_t      state, state_nx;
    logic [15:0] addr, len, idx, len_full;
    logic [16:0] span;
    logic [7:0]  csum;
    logic        range_err, alive, acc;
    // alive keeps s_ready low while reset is held and releases it on the first clock afterwards
    assign s_ready  = alive && state != RESP;
    assign acc      = s_valid && s_ready;
    assign cpu_hold = state != IDLE;
    assign len_full = {s_data, len[7:0]};
    // 17-bit sum so that an address near 64K cannot wrap into the legal range
    assign span     = {1'b0, addr} + {1'b0, len_full};
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = acc && s_data == SYNC_BYTE ? ADDR0 : IDLE;
            ADDR0:   state_nx = acc ? ADDR1 : ADDR0;
            ADDR1:   state_nx = acc ? LEN0 : ADDR1;
            LEN0:    state_nx = acc ? LEN1 : LEN0;
            LEN1:    state_nx = acc ? (len_full == 16'd0 ? CSUM : DATA) : LEN1;
            DATA:    state_nx = acc && idx + 16'd1 == len ? CSUM : DATA;
            CSUM:    state_nx = acc ? RESP : CSUM;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            len       <= '0;
            idx       <= '0;
            csum      <= '0;
            range_err <= 1'b0;
            alive     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            status    <= ST_OK;
        end else begin
            state <= state_nx;
            alive <= 1'b1;
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (acc) begin
                case (state)
                    ADDR0: addr[7:0]  <= s_data;
                    ADDR1: addr[15:8] <= s_data;
                    LEN0:  len[7:0]   <= s_data;
                    LEN1: begin
                        len[15:8] <= s_data;
                        range_err <= span > 17'(MEM_BYTES);
                        idx       <= '0;
                        csum      <= '0;
                    end
                    DATA: begin
                        csum    <= csum ^ s_data;
                        idx     <= idx + 16'd1;
                        wr_en   <= !range_err;
                        wr_addr <= {{(ADDR_W-16){1'b0}}, addr + idx};
                        wr_data <= s_data;
                    end
                    CSUM: begin
                        done   <= 1'b1;
                        status <= range_err ? ST_RANGE : (csum != s_data ? ST_CSUM : ST_OK);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_im_program_loader.sv
// tb_im_program_loader: table-driven, hand-sequenced and randomized checks of im_program_loader
module tb_im_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, wr_en, cpu_hold, done;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  status;

    im_program_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .done(done), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        int          l;
        logic [31:0] p;
        logic [7:0]  cs;
        int          npre;
        int          gm;
        logic [1:0]  st;
        int          nwr;
    } vec_t;

    vec_t        tbl [9];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          rdy_bad = 0;
    logic        chk_rdy = 1'b0;
    logic        hold_pend = 1'b0;
    logic        hold_at, hold_after;
    logic [1:0]  st_cap;
    logic [71:0] wq [$];
    logic [71:0] ew [$];
    logic [7:0]  pl [$];

    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (hold_pend) begin
            hold_after = cpu_hold;
            hold_pend  = 1'b0;
        end
        if (done) begin
            st_cap    = status;
            hold_at   = cpu_hold;
            hold_pend = 1'b1;
            done_cnt++;
        end
        if (chk_rdy && rst_n && !s_ready && !done) rdy_bad++;
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a frame either fits entirely in memory and writes every payload byte in order,
    // or writes nothing; range error outranks a checksum mismatch.
    function automatic int model(input int a, input int l, input logic [7:0] cs);
        logic [7:0] x = 8'h00;
        ew.delete();
        foreach (pl[i]) x ^= pl[i];
        if (a + l > 512) return 2;
        for (int i = 0; i < l; i++) ew.push_back({64'(a + i), pl[i]});
        return (x != cs) ? 1 : 0;
    endfunction

    task automatic send(input logic [7:0] b, input int g);
        int n = 0;
        s_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("ready_timeout", 72'(s_ready), 72'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    function automatic int gap(input int gm);
        return gm == 0 ? 0 : (gm == 1 ? 1 : int'($urandom_range(0, 2)));
    endfunction

    task automatic run_frame(input int a, input int l, input logic [7:0] cs, input int npre,
                             input int gm, input int exp_st, input int exp_nwr);
        logic [7:0] junk [3];
        int d0, n, mst;
        junk[0] = 8'h00;
        junk[1] = 8'hFF;
        junk[2] = 8'h3C;
        mst = model(a, l, cs);
        if (exp_st < 0) exp_st = mst;
        if (exp_nwr < 0) exp_nwr = ew.size();
        wq.delete();
        rdy_bad = 0;
        d0 = done_cnt;
        for (int i = 0; i < npre; i++) send(junk[i % 3], gap(gm));
        send(8'hA5, gap(gm));
        send(8'(a), gap(gm));
        send(8'(a >> 8), gap(gm));
        send(8'(l), gap(gm));
        send(8'(l >> 8), gap(gm));
        foreach (pl[i]) send(pl[i], gap(gm));
        send(cs, gap(gm));
        n = 0;
        while (done_cnt == d0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("done_count", 72'(done_cnt - d0), 72'd1);
        chk("status", 72'(st_cap), 72'(exp_st));
        chk("hold_at_done", 72'(hold_at), 72'd1);
        chk("hold_after_done", 72'(hold_after), 72'd0);
        chk("write_count", 72'(wq.size()), 72'(exp_nwr));
        for (int i = 0; i < wq.size() && i < ew.size(); i++) chk("write", wq[i], ew[i]);
        if (chk_rdy) chk("ready_low_only_in_resp", 72'(rdy_bad), 72'd0);
    endtask

    task automatic load_payload(input logic [31:0] p, input int l);
        pl.delete();
        for (int j = 0; j < l; j++) pl.push_back(p[8*j +: 8]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h004, 4, 32'h00010083, 8'h82, 0, 0, 2'b00, 4};
        tbl[1] = '{32'h004, 4, 32'h00010083, 8'h00, 0, 0, 2'b01, 4};
        tbl[2] = '{32'h1FE, 4, 32'h44332211, 8'h44, 0, 0, 2'b10, 0};
        tbl[3] = '{32'h028, 0, 32'h00000000, 8'h00, 3, 0, 2'b00, 0};
        tbl[4] = '{32'h1FC, 4, 32'hDDCCBBAA, 8'h00, 0, 2, 2'b00, 4};
        tbl[5] = '{32'h1FD, 4, 32'hDDCCBBAA, 8'h5A, 0, 0, 2'b10, 0};
        tbl[6] = '{32'hFFFF, 1, 32'h000000A5, 8'hA5, 0, 0, 2'b10, 0};
        tbl[7] = '{32'h0A5, 3, 32'h00A5A5A5, 8'hA5, 0, 2, 2'b00, 3};
        tbl[8] = '{32'h004, 4, 32'h00010083, 8'h82, 0, 1, 2'b00, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {s_ready, wr_en, wr_addr, wr_data, cpu_hold, done, status},
            72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            load_payload(tbl[k].p, tbl[k].l);
            chk_rdy = tbl[k].gm == 1;
            run_frame(tbl[k].a, tbl[k].l, tbl[k].cs, tbl[k].npre, tbl[k].gm,
                      int'(tbl[k].st), tbl[k].nwr);
            chk_rdy = 1'b0;
        end

        load_payload(32'h00010083, 4);
        send(8'hA5, 0);
        send(8'h04, 0);
        send(8'h00, 0);
        send(8'h04, 0);
        send(8'h00, 0);
        send(8'h83, 0);
        send(8'h00, 0);
        s_valid = 1'b1;
        s_data  = 8'h01;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            {s_ready, wr_en, wr_addr, wr_data, cpu_hold, done, status}, 72'd0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        run_frame(4, 4, 8'h82, 0, 0, 0, 4);

        for (int r = 0; r < 30; r++) begin
            int a, l;
            logic [7:0] x = 8'h00;
            logic [7:0] cs;
            a = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 530));
            l = $urandom_range(0, 12);
            pl.delete();
            for (int j = 0; j < l; j++) begin
                pl.push_back(8'($urandom));
                x ^= pl[j];
            end
            cs = $urandom_range(0, 9) < 7 ? x : 8'($urandom);
            run_frame(a, l, cs, $urandom_range(0, 2), 2, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
